// File: rtl/otg_hpi_pkg.sv
// Shared types and constants for the OTG HPI responder: register map, STATUS bit positions, FSM states.
package otg_hpi_pkg;

    localparam int unsigned HPI_DW = 16;

    typedef enum logic [1:0] {
        HPI_DATA    = 2'd0,
        HPI_MAILBOX = 2'd1,
        HPI_ADDRESS = 2'd2,
        HPI_STATUS  = 2'd3
    } hpi_reg_e;

    localparam int unsigned STS_MBX_OUT_BIT = 0;
    localparam int unsigned STS_MBX_IN_BIT  = 1;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_WR       = 3'd1,
        ST_WAIT_END = 3'd2,
        ST_RD_LAT   = 3'd3,
        ST_RD_HOLD  = 3'd4
    } hpi_state_e;

    function automatic logic [HPI_DW-1:0] sts_word(input logic mbx_in, input logic mbx_out);
        logic [HPI_DW-1:0] s;
        s                  = '0;
        s[STS_MBX_IN_BIT]  = mbx_in;
        s[STS_MBX_OUT_BIT] = mbx_out;
        return s;
    endfunction

endpackage

// File: rtl/otg_hpi_resp_ram.sv
// Single-port MEM_WORDS x 16 synchronous RAM with a 1-cycle registered read; contents are never reset.
module otg_hpi_resp_ram #(
    parameter int unsigned MEM_WORDS = 1024,
    parameter int unsigned AW        = $clog2(MEM_WORDS)
) (
    input  logic          clk_i,
    input  logic          en_i,
    input  logic          we_i,
    input  logic [AW-1:0] addr_i,
    input  logic [15:0]   wdata_i,
    output logic [15:0]   rdata_o
);

    logic [15:0] mem_q [MEM_WORDS];
    logic [15:0] rdata_q;

    // Read data only updates on a read, so it stays stable through the read latency window.
    always_ff @(posedge clk_i) begin
        if (en_i) begin
            if (we_i) begin
                mem_q[addr_i] <= wdata_i;
            end else begin
                rdata_q <= mem_q[addr_i];
            end
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/otg_hpi_responder.sv
// Device-side HPI responder: DATA/MAILBOX/ADDRESS/STATUS map over an internal word RAM plus a fabric mailbox.
// Define OTG_HPI_PROTO_CHECK_EN to add the saturating proto_err_cnt output.
module otg_hpi_responder
    import otg_hpi_pkg::*;
#(
    parameter int unsigned MEM_WORDS = 1024,
    parameter int unsigned READ_LAT  = 2
) (
    input  logic        clk_clk,
    input  logic        reset_reset_n,
    input  logic        hpi_rst_n,
    input  logic [1:0]  hpi_addr,
    input  logic        hpi_cs_n,
    input  logic        hpi_r_n,
    input  logic        hpi_w_n,
    input  logic [15:0] hpi_data_in,
    output logic [15:0] hpi_data_out,
    output logic        hpi_data_oe,
    output logic        hpi_int,
    output logic        mbx_in_valid,
    output logic [15:0] mbx_in_data,
    input  logic        mbx_in_ack,
    input  logic        mbx_out_wr,
    input  logic [15:0] mbx_out_data,
    output logic        mbx_out_busy
`ifdef OTG_HPI_PROTO_CHECK_EN
    ,
    output logic [7:0]  proto_err_cnt
`endif
);

    localparam int unsigned AW = $clog2(MEM_WORDS);
    localparam int unsigned LW = 3;

    logic     rst_c;
    logic     rd_acc_c;
    logic     wr_acc_c;
    hpi_reg_e reg_sel_c;

    assign rst_c     = !reset_reset_n || !hpi_rst_n;
    assign rd_acc_c  = !hpi_cs_n && !hpi_r_n && hpi_w_n;
    assign wr_acc_c  = !hpi_cs_n && hpi_r_n && !hpi_w_n;
    assign reg_sel_c = hpi_reg_e'(hpi_addr);

    hpi_state_e state_q, state_d;

    logic [15:0]   ptr_q, ptr_d;
    logic [LW-1:0] lat_q, lat_d;
    hpi_reg_e      rd_reg_q, rd_reg_d;
    logic [15:0]   snap_q, snap_d;
    logic          mbx_in_flag_q, mbx_in_flag_d;
    logic [15:0]   mbx_in_word_q, mbx_in_word_d;
    logic          mbx_out_flag_q, mbx_out_flag_d;
    logic [15:0]   mbx_out_word_q, mbx_out_word_d;
    logic [15:0]   data_out_q, data_out_d;
    logic          oe_q, oe_d;

    logic        wr_start_c, rd_start_c, load_c, rd_end_c;
    logic        ram_en_c, ram_we_c, ptr_load_c, ptr_inc_c;
    logic        mbx_in_wr_c, mbx_clr_c;
    logic [15:0] ram_rdata;

    // FSM state register
    always_ff @(posedge clk_clk) begin
        if (rst_c) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (wr_acc_c) begin
                    state_d = ST_WR;
                end else if (rd_acc_c) begin
                    state_d = ST_RD_LAT;
                end
            end
            ST_WR:       state_d = ST_WAIT_END;
            ST_WAIT_END: if (!wr_acc_c) state_d = ST_IDLE;
            ST_RD_LAT: begin
                if (!rd_acc_c) begin
                    state_d = ST_IDLE;
                end else if (lat_q == LW'(READ_LAT)) begin
                    state_d = ST_RD_HOLD;
                end
            end
            ST_RD_HOLD:  if (!rd_acc_c) state_d = ST_IDLE;
            default:     state_d = ST_IDLE;
        endcase
    end

    // FSM outputs: one-cycle action strobes; a read ending early in RD_LAT has no side effects
    always_comb begin
        wr_start_c  = (state_q == ST_IDLE) && wr_acc_c && !rst_c;
        rd_start_c  = (state_q == ST_IDLE) && rd_acc_c && !rst_c;
        load_c      = (state_q == ST_RD_LAT) && rd_acc_c && (lat_q == LW'(READ_LAT));
        rd_end_c    = (state_q == ST_RD_HOLD) && !rd_acc_c;
        ram_we_c    = wr_start_c && (reg_sel_c == HPI_DATA);
        ram_en_c    = ram_we_c || (rd_start_c && (reg_sel_c == HPI_DATA));
        ptr_load_c  = wr_start_c && (reg_sel_c == HPI_ADDRESS);
        ptr_inc_c   = ram_we_c || (rd_end_c && (rd_reg_q == HPI_DATA));
        mbx_in_wr_c = wr_start_c && (reg_sel_c == HPI_MAILBOX);
        mbx_clr_c   = rd_end_c && (rd_reg_q == HPI_MAILBOX);
    end

    // Datapath next state
    always_comb begin
        ptr_d          = ptr_q;
        lat_d          = lat_q;
        rd_reg_d       = rd_reg_q;
        snap_d         = snap_q;
        mbx_in_flag_d  = mbx_in_flag_q;
        mbx_in_word_d  = mbx_in_word_q;
        mbx_out_flag_d = mbx_out_flag_q;
        mbx_out_word_d = mbx_out_word_q;
        data_out_d     = data_out_q;
        oe_d           = oe_q;

        if (ptr_load_c) begin
            ptr_d = hpi_data_in;
        end else if (ptr_inc_c) begin
            ptr_d = ptr_q + 16'd2;
        end

        // Non-RAM registers are snapshotted at strobe start; DATA comes from the RAM read port.
        if (rd_start_c) begin
            rd_reg_d = reg_sel_c;
            lat_d    = LW'(1);
            case (reg_sel_c)
                HPI_ADDRESS: snap_d = ptr_q;
                HPI_STATUS:  snap_d = sts_word(mbx_in_flag_q, mbx_out_flag_q);
                HPI_MAILBOX: snap_d = mbx_out_word_q;
                default:     snap_d = 16'h0000;
            endcase
        end else if (state_q == ST_RD_LAT) begin
            lat_d = lat_q + LW'(1);
        end

        if (load_c) begin
            data_out_d = (rd_reg_q == HPI_DATA) ? ram_rdata : snap_q;
            oe_d       = 1'b1;
        end else if (rd_end_c) begin
            oe_d = 1'b0;
        end

        // Host write wins over a same-cycle fabric ack.
        if (mbx_in_wr_c) begin
            mbx_in_word_d = hpi_data_in;
            mbx_in_flag_d = 1'b1;
        end else if (mbx_in_ack && mbx_in_flag_q) begin
            mbx_in_flag_d = 1'b0;
        end

        // Fabric write wins over a same-cycle host read-clear; otherwise dropped while busy.
        if (mbx_out_wr && (!mbx_out_flag_q || mbx_clr_c)) begin
            mbx_out_word_d = mbx_out_data;
            mbx_out_flag_d = 1'b1;
        end else if (mbx_clr_c) begin
            mbx_out_flag_d = 1'b0;
        end
    end

    always_ff @(posedge clk_clk) begin
        if (rst_c) begin
            ptr_q          <= '0;
            lat_q          <= '0;
            rd_reg_q       <= HPI_DATA;
            snap_q         <= '0;
            mbx_in_flag_q  <= 1'b0;
            mbx_in_word_q  <= '0;
            mbx_out_flag_q <= 1'b0;
            mbx_out_word_q <= '0;
            data_out_q     <= '0;
            oe_q           <= 1'b0;
        end else begin
            ptr_q          <= ptr_d;
            lat_q          <= lat_d;
            rd_reg_q       <= rd_reg_d;
            snap_q         <= snap_d;
            mbx_in_flag_q  <= mbx_in_flag_d;
            mbx_in_word_q  <= mbx_in_word_d;
            mbx_out_flag_q <= mbx_out_flag_d;
            mbx_out_word_q <= mbx_out_word_d;
            data_out_q     <= data_out_d;
            oe_q           <= oe_d;
        end
    end

    otg_hpi_resp_ram #(
        .MEM_WORDS (MEM_WORDS),
        .AW        (AW)
    ) u_ram (
        .clk_i   (clk_clk),
        .en_i    (ram_en_c),
        .we_i    (ram_we_c),
        .addr_i  (ptr_q[AW:1]),
        .wdata_i (hpi_data_in),
        .rdata_o (ram_rdata)
    );

    assign hpi_data_out = data_out_q;
    assign hpi_data_oe  = oe_q;
    assign hpi_int      = mbx_out_flag_q;
    assign mbx_out_busy = mbx_out_flag_q;
    assign mbx_in_valid = mbx_in_flag_q;
    assign mbx_in_data  = mbx_in_word_q;

`ifdef OTG_HPI_PROTO_CHECK_EN
    logic       both_c, both_q, err_c;
    logic [7:0] err_cnt_q, err_cnt_d;

    // A held simultaneous r/w strobe counts once, on its first cycle.
    always_comb begin
        both_c    = !hpi_cs_n && !hpi_r_n && !hpi_w_n;
        err_c     = (both_c && !both_q) ||
                    (wr_start_c && (reg_sel_c == HPI_STATUS)) ||
                    (mbx_in_wr_c && mbx_in_flag_q);
        err_cnt_d = (err_c && (err_cnt_q != 8'hFF)) ? err_cnt_q + 8'd1 : err_cnt_q;
    end

    always_ff @(posedge clk_clk) begin
        if (rst_c) begin
            both_q    <= 1'b0;
            err_cnt_q <= '0;
        end else begin
            both_q    <= both_c;
            err_cnt_q <= err_cnt_d;
        end
    end

    assign proto_err_cnt = err_cnt_q;
`endif

endmodule

// File: tb/tb_otg_hpi_responder.sv
// Scoreboard bench for otg_hpi_responder: host reads push expected words, a forked monitor compares on oe rise.
module tb_otg_hpi_responder;

    localparam int unsigned READ_LAT = 2;
    localparam logic [1:0] A_DATA = 2'd0, A_MBX = 2'd1, A_ADDR = 2'd2, A_STS = 2'd3;

    logic        clk = 1'b0;
    logic        rst_n, hpi_rst_n;
    logic [1:0]  addr;
    logic        cs_n, r_n, w_n;
    logic [15:0] din, dout;
    logic        oe, irq, in_valid, in_ack, out_wr, out_busy;
    logic [15:0] in_data, out_data;
`ifdef OTG_HPI_PROTO_CHECK_EN
    logic [7:0]  err_cnt;
`endif

    int checks = 0;
    int failures = 0;
    logic [15:0] exp_q[$];

    always #5 clk = ~clk;

    otg_hpi_responder #(.MEM_WORDS(1024), .READ_LAT(READ_LAT)) dut (
        .clk_clk       (clk),
        .reset_reset_n (rst_n),
        .hpi_rst_n     (hpi_rst_n),
        .hpi_addr      (addr),
        .hpi_cs_n      (cs_n),
        .hpi_r_n       (r_n),
        .hpi_w_n       (w_n),
        .hpi_data_in   (din),
        .hpi_data_out  (dout),
        .hpi_data_oe   (oe),
        .hpi_int       (irq),
        .mbx_in_valid  (in_valid),
        .mbx_in_data   (in_data),
        .mbx_in_ack    (in_ack),
        .mbx_out_wr    (out_wr),
        .mbx_out_data  (out_data),
        .mbx_out_busy  (out_busy)
`ifdef OTG_HPI_PROTO_CHECK_EN
        ,
        .proto_err_cnt (err_cnt)
`endif
    );

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic monitor();
        logic prev = 1'b0;
        logic [15:0] e;
        forever begin
            @(negedge clk);
            if (oe && !prev) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL rd_unexpected: got %h expected no read", dout);
                end else begin
                    e = exp_q.pop_front();
                    chk("rd_data", dout, e);
                end
            end
            prev = oe;
        end
    endtask

    task automatic idle_bus();
        cs_n = 1'b1; r_n = 1'b1; w_n = 1'b1;
    endtask

    // Strobe held two cycles to prove a held write commits once.
    task automatic host_write(input logic [1:0] a, input logic [15:0] d);
        addr = a; din = d; cs_n = 1'b0; w_n = 1'b0;
        repeat (2) @(negedge clk);
        idle_bus();
        repeat (2) @(negedge clk);
    endtask

    task automatic host_read(input logic [1:0] a, input logic [15:0] exp);
        int k;
        exp_q.push_back(exp);
        addr = a; cs_n = 1'b0; r_n = 1'b0;
        k = 0;
        while (k < 20) begin
            @(negedge clk);
            k++;
            if (oe) break;
        end
        chk("rd_latency", 16'(k), 16'(READ_LAT + 1));
        idle_bus();
        @(negedge clk);
        chk("oe_drop", 16'(oe), 16'h0);
        @(negedge clk);
    endtask

    task automatic fab_write(input logic [15:0] d);
        out_wr = 1'b1; out_data = d;
        @(negedge clk);
        out_wr = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; hpi_rst_n = 1'b1; addr = 2'd0; din = '0;
        in_ack = 1'b0; out_wr = 1'b0; out_data = '0;
        idle_bus();
        fork
            monitor();
        join_none
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_oe", 16'(oe), 16'h0);
        chk("rst_dout", dout, 16'h0);
        chk("rst_int", 16'(irq), 16'h0);
        chk("rst_in_valid", 16'(in_valid), 16'h0);
        chk("rst_busy", 16'(out_busy), 16'h0);
`ifdef OTG_HPI_PROTO_CHECK_EN
        chk("rst_err_cnt", 16'(err_cnt), 16'h0);
`endif
        host_read(A_STS, 16'h0000);
        host_read(A_ADDR, 16'h0000);

        // RAM burst write/read with pointer auto-increment
        host_write(A_ADDR, 16'h0100);
        host_write(A_DATA, 16'hA5A5);
        host_write(A_DATA, 16'h5A5A);
        host_write(A_ADDR, 16'h0100);
        host_read(A_DATA, 16'hA5A5);
        host_read(A_DATA, 16'h5A5A);
        host_read(A_ADDR, 16'h0104);

        // Pointer wrap and top RAM word
        host_write(A_ADDR, 16'hFFFE);
        host_write(A_DATA, 16'h1234);
        host_read(A_ADDR, 16'h0000);
        host_write(A_ADDR, 16'h07FE);
        host_read(A_DATA, 16'h1234);

        // Fabric -> host mailbox
        fab_write(16'hBEEF);
        chk("int_set", 16'(irq), 16'h1);
        chk("busy_set", 16'(out_busy), 16'h1);
        host_read(A_STS, 16'h0001);
        host_read(A_MBX, 16'hBEEF);
        chk("int_clr", 16'(irq), 16'h0);
        fab_write(16'h1111);
        fab_write(16'h2222);
        host_read(A_MBX, 16'h1111);

        // Host -> fabric mailbox
        host_write(A_MBX, 16'h00C3);
        chk("in_valid_set", 16'(in_valid), 16'h1);
        chk("in_data", in_data, 16'h00C3);
        host_read(A_STS, 16'h0002);
        in_ack = 1'b1;
        @(negedge clk);
        in_ack = 1'b0;
        chk("in_valid_clr", 16'(in_valid), 16'h0);
        host_read(A_STS, 16'h0000);

        // Simultaneous r/w: no access
        host_write(A_ADDR, 16'h0100);
        addr = A_DATA; din = 16'hDEAD; cs_n = 1'b0; r_n = 1'b0; w_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rw_oe", 16'(oe), 16'h0);
        end
        idle_bus();
        @(negedge clk);
`ifdef OTG_HPI_PROTO_CHECK_EN
        chk("err_rw", 16'(err_cnt), 16'h1);
`endif
        host_read(A_ADDR, 16'h0100);
        host_read(A_DATA, 16'hA5A5);
`ifdef OTG_HPI_PROTO_CHECK_EN
        host_write(A_STS, 16'hFFFF);
        chk("err_sts", 16'(err_cnt), 16'h2);
`endif
        host_read(A_STS, 16'h0000);

        // Read released before latency: no data, pointer unchanged
        host_write(A_ADDR, 16'h0100);
        addr = A_DATA; cs_n = 1'b0; r_n = 1'b0;
        @(negedge clk);
        idle_bus();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("short_oe", 16'(oe), 16'h0);
        end
        host_read(A_ADDR, 16'h0100);

        // Mailbox overwrite keeps the newest word
        host_write(A_MBX, 16'h0042);
        host_write(A_MBX, 16'h0043);
        chk("ovr_data", in_data, 16'h0043);
`ifdef OTG_HPI_PROTO_CHECK_EN
        chk("err_ovr", 16'(err_cnt), 16'h3);
`endif

        // Host soft reset in the middle of a read
        fab_write(16'h7777);
        chk("pre_rst_busy", 16'(out_busy), 16'h1);
        chk("pre_rst_dout", dout, 16'h0100);
        addr = A_DATA; cs_n = 1'b0; r_n = 1'b0;
        @(negedge clk);
        hpi_rst_n = 1'b0;
        idle_bus();
        @(negedge clk);
        hpi_rst_n = 1'b1;
        chk("srst_oe", 16'(oe), 16'h0);
        chk("srst_dout", dout, 16'h0);
        chk("srst_int", 16'(irq), 16'h0);
        chk("srst_in_valid", 16'(in_valid), 16'h0);
        chk("srst_busy", 16'(out_busy), 16'h0);
`ifdef OTG_HPI_PROTO_CHECK_EN
        chk("srst_err_cnt", 16'(err_cnt), 16'h0);
`endif
        repeat (2) @(negedge clk);
        chk("srst_no_oe", 16'(oe), 16'h0);
        host_read(A_ADDR, 16'h0000);
        host_read(A_STS, 16'h0000);
        host_write(A_ADDR, 16'h0100);
        host_read(A_DATA, 16'hA5A5);

        repeat (3) @(negedge clk);
        chk("sb_drained", 16'(exp_q.size()), 16'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
